// File: rtl/trig_antsel_if.sv
// Bundle of trigger-path signals between the TRIG_IN pins, the filter/decoder
// and the MCU-facing outputs, plus the FSM state for observation.
interface trig_antsel_if #(
    parameter int N_TRIG = 4,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 16
);
    // No valid/ready pair here: trig_pulse is a one-cycle strobe qualifying
    // antsel and trig_cnt, which are stable from that cycle until the next strobe.
    logic [N_TRIG-1:0] trig_in;
    logic              enable;
    logic              clr_err;
    logic [N_TRIG-1:0] trigflt;
    logic [SEL_W-1:0]  antsel;
    logic              trig_out;
    logic              trig_pulse;
    logic              multi_err;
    logic [CNT_W-1:0]  trig_cnt;
    logic [1:0]        dbg_state;

    modport master (
        output trig_in, enable, clr_err,
        input  trigflt, antsel, trig_out, trig_pulse, multi_err, trig_cnt, dbg_state
    );

    modport slave (
        input  trig_in, enable, clr_err,
        output trigflt, antsel, trig_out, trig_pulse, multi_err, trig_cnt, dbg_state
    );
endinterface

// File: rtl/trig_antsel.sv
// Trigger input debounce, one-hot antenna-select decode and trigger FSM
// with latch delay, hold-off, saturating accept counter and multi-trigger flag.
module trig_antsel #(
    parameter int N_TRIG    = 4,
    parameter int SEL_W     = 3,
    parameter int FILT_N    = 1000,
    parameter int LATCH_DLY = 2,
    parameter int HOLDOFF   = 100,
    parameter int CNT_W     = 16
) (
    input logic          clk100,
    input logic          rst,
    trig_antsel_if.slave bus
);
    localparam int FW = (FILT_N < 2) ? 1 : $clog2(FILT_N + 1);
    localparam int DW = $clog2(LATCH_DLY + 1);
    localparam int HW = $clog2(HOLDOFF + 2);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_N - 1);
    localparam logic [DW-1:0] DLY_LD    = DW'(LATCH_DLY - 1);
    localparam logic [HW-1:0] HOLD_LD   = HW'(HOLDOFF);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DELAY   = 2'd1,
        S_ACTIVE  = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    logic [N_TRIG-1:0] sync1, sync2;
    logic [N_TRIG-1:0] flt_q;
    logic [N_TRIG-1:0] flt;
    logic [N_TRIG-1:0] flt_d;
    logic [FW-1:0]     fcnt [N_TRIG];

    state_t            state, next_state;
    logic [DW-1:0]     dcnt, dcnt_n;
    logic [HW-1:0]     hcnt, hcnt_n;

    logic [SEL_W-1:0]  antsel_q, antsel_n;
    logic              pulse_q, pulse_n;
    logic              tout_q, tout_n;
    logic              merr_q, merr_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;

    logic [3:0]        n_set;
    logic [SEL_W-1:0]  code;
    logic              is_one, is_multi;
    logic              any, any_d, any_rise, new_bits;
    logic              sample, set_err;

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.trig_in;
            sync2 <= sync1;
        end
    end

    // A bit only moves once its synchronised value has disagreed for FILT_N cycles in a row.
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            flt_q <= '0;
            for (int i = 0; i < N_TRIG; i++) fcnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_TRIG; i++) begin
                if (sync2[i] == flt_q[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_LAST) begin
                    flt_q[i] <= sync2[i];
                    fcnt[i]  <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign flt         = flt_q;
    assign bus.trigflt = flt;

    always_comb begin
        n_set = '0;
        code  = '1;
        for (int i = 0; i < N_TRIG; i++) begin
            if (flt[i]) begin
                n_set = n_set + 4'd1;
                code  = SEL_W'(i);
            end
        end
    end

    assign is_one   = (n_set == 4'd1);
    assign is_multi = (n_set > 4'd1);

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) flt_d <= '0;
        else     flt_d <= flt;
    end

    assign any      = |flt;
    assign any_d    = |flt_d;
    assign any_rise = any & ~any_d;
    assign new_bits = |(flt & ~flt_d);

    // The IDLE cycle that sees any_rise counts as the first latch-delay cycle.
    assign sample = bus.enable &&
                    (((state == S_DELAY) && (dcnt == DW'(1))) ||
                     ((state == S_IDLE) && any_rise && (LATCH_DLY == 1)));

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            dcnt  <= '0;
            hcnt  <= '0;
        end else begin
            state <= next_state;
            dcnt  <= dcnt_n;
            hcnt  <= hcnt_n;
        end
    end

    always_comb begin
        next_state = state;
        dcnt_n     = dcnt;
        hcnt_n     = hcnt;
        if (!bus.enable) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_rise) begin
                        if (LATCH_DLY == 1) begin
                            next_state = (is_one || is_multi) ? S_ACTIVE : S_IDLE;
                        end else begin
                            next_state = S_DELAY;
                            dcnt_n     = DLY_LD;
                        end
                    end
                end
                S_DELAY: begin
                    if (dcnt == DW'(1)) next_state = (is_one || is_multi) ? S_ACTIVE : S_IDLE;
                    else                dcnt_n = dcnt - 1'b1;
                end
                S_ACTIVE: begin
                    if (!any) begin
                        if (HOLDOFF == 0) begin
                            next_state = S_IDLE;
                        end else begin
                            next_state = S_HOLDOFF;
                            hcnt_n     = HOLD_LD;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (hcnt <= HW'(1)) next_state = S_IDLE;
                    else                hcnt_n = hcnt - 1'b1;
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pulse_n  = sample && is_one;
        antsel_n = pulse_n ? code : antsel_q;
        cnt_n    = (pulse_n && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
        set_err  = bus.enable &&
                   ((sample && is_multi) || ((state == S_ACTIVE) && new_bits));
        // Setting wins over a coincident clear.
        if (set_err)          merr_n = 1'b1;
        else if (bus.clr_err) merr_n = 1'b0;
        else                  merr_n = merr_q;
        tout_n   = (next_state == S_ACTIVE);
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            antsel_q <= '1;
            pulse_q  <= 1'b0;
            tout_q   <= 1'b0;
            merr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            antsel_q <= antsel_n;
            pulse_q  <= pulse_n;
            tout_q   <= tout_n;
            merr_q   <= merr_n;
            cnt_q    <= cnt_n;
        end
    end

    assign bus.antsel     = antsel_q;
    assign bus.trig_pulse = pulse_q;
    assign bus.trig_out   = tout_q;
    assign bus.multi_err  = merr_q;
    assign bus.trig_cnt   = cnt_q;
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_trig_antsel.sv
// Bench for trig_antsel: FILT_N=8, LATCH_DLY=2, HOLDOFF=4, N_TRIG=4, plus a
// CNT_W=2 copy sharing the same inputs to exercise counter saturation.
module tb_trig_antsel;
  localparam int N_TRIG = 4;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 16;
  localparam int EW     = CNT_W + SEL_W;

  logic clk100 = 1'b0;
  logic rst    = 1'b1;

  trig_antsel_if #(.N_TRIG(N_TRIG), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();
  trig_antsel_if #(.N_TRIG(N_TRIG), .SEL_W(SEL_W), .CNT_W(2))     bus2 ();

  assign bus2.trig_in = bus.trig_in;
  assign bus2.enable  = bus.enable;
  assign bus2.clr_err = bus.clr_err;

  trig_antsel #(.N_TRIG(N_TRIG), .SEL_W(SEL_W), .FILT_N(8), .LATCH_DLY(2),
                .HOLDOFF(4), .CNT_W(CNT_W)) dut (
    .clk100 (clk100),
    .rst    (rst),
    .bus    (bus)
  );

  trig_antsel #(.N_TRIG(N_TRIG), .SEL_W(SEL_W), .FILT_N(8), .LATCH_DLY(2),
                .HOLDOFF(4), .CNT_W(2)) dut2 (
    .clk100 (clk100),
    .rst    (rst),
    .bus    (bus2)
  );

  // clock / reset
  always #5 clk100 = ~clk100;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int   exp_cnt  = 0;
  int   last_sel = 7;
  bit   mon_en   = 1'b0;
  bit   seen;
  int   rb, rlen;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk100);
  endtask

  task automatic expect_trig(input int b);
    exp_cnt++;
    last_sel = b;
    exp_q.push_back({CNT_W'(exp_cnt), SEL_W'(b)});
  endtask

  // scoreboard: every strobe must match the oldest queued expectation
  always @(negedge clk100) begin
    if (mon_en && bus.trig_pulse) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_antsel", 32'(bus.antsel), 32'(mon_e[SEL_W-1:0]));
        check("pulse_cnt", 32'(bus.trig_cnt), 32'(mon_e[EW-1:SEL_W]));
      end
    end
  end

  initial begin
    bus.trig_in = '0;
    bus.enable  = 1'b0;
    bus.clr_err = 1'b0;

    // reset and idle
    tick(3);
    check("rst_antsel", 32'(bus.antsel), 32'h7);
    check("rst_cnt", 32'(bus.trig_cnt), 32'h0);
    rst = 1'b0;
    bus.enable = 1'b1;
    check("rel_antsel", 32'(bus.antsel), 32'h7);
    check("rel_tout", 32'(bus.trig_out), 32'h0);
    check("rel_merr", 32'(bus.multi_err), 32'h0);
    check("rel_flt", 32'(bus.trigflt), 32'h0);
    check("rel_state", 32'(bus.dbg_state), 32'h0);
    mon_en = 1'b1;
    tick(100);
    check("idle_antsel", 32'(bus.antsel), 32'h7);
    check("idle_cnt", 32'(bus.trig_cnt), 32'h0);
    check("idle_tout", 32'(bus.trig_out), 32'h0);

    // glitch rejection: 7-cycle pulse must not pass an 8-cycle filter
    bus.trig_in = 4'b0100;
    tick(7);
    bus.trig_in = '0;
    seen = 1'b0;
    repeat (20) begin
      tick(1);
      if (bus.trigflt != '0) seen = 1'b1;
    end
    check("glitch_rejected", 32'(seen), 32'h0);

    // held trigger on bit 2
    bus.trig_in = 4'b0100;
    expect_trig(2);
    tick(9);
    check("flt_before_10", 32'(bus.trigflt), 32'h0);
    tick(1);
    check("flt_at_10", 32'(bus.trigflt), 32'h4);
    tick(1);
    check("pulse_at_11", 32'(bus.trig_pulse), 32'h0);
    tick(1);
    check("pulse_at_12", 32'(bus.trig_pulse), 32'h1);
    check("antsel_b2", 32'(bus.antsel), 32'h2);
    check("cnt_1", 32'(bus.trig_cnt), 32'h1);
    check("tout_active", 32'(bus.trig_out), 32'h1);
    tick(8);
    bus.trig_in = '0;
    tick(10);
    check("tout_rel_10", 32'(bus.trig_out), 32'h1);
    tick(1);
    check("tout_rel_11", 32'(bus.trig_out), 32'h0);
    check("state_holdoff", 32'(bus.dbg_state), 32'h3);
    tick(10);

    // multi-trigger
    bus.trig_in = 4'b1001;
    tick(12);
    check("multi_err_set", 32'(bus.multi_err), 32'h1);
    check("multi_no_pulse", 32'(bus.trig_pulse), 32'h0);
    check("multi_antsel_kept", 32'(bus.antsel), 32'h2);
    check("multi_tout", 32'(bus.trig_out), 32'h1);
    tick(2);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    check("multi_err_cleared", 32'(bus.multi_err), 32'h0);
    bus.trig_in = 4'b1011;
    tick(10);
    check("merr_before_new", 32'(bus.multi_err), 32'h0);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    check("merr_set_wins", 32'(bus.multi_err), 32'h1);
    bus.trig_in = '0;
    tick(20);
    check("merr_sticky", 32'(bus.multi_err), 32'h1);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    check("merr_clear_idle", 32'(bus.multi_err), 32'h0);
    check("multi_back_idle", 32'(bus.dbg_state), 32'h0);

    // hold-off: second edge lands 2 cycles into HOLDOFF and is ignored
    bus.trig_in = 4'b0010;
    expect_trig(1);
    tick(15);
    bus.trig_in = '0;
    tick(3);
    bus.trig_in = 4'b1000;
    tick(10);
    check("ho_in_holdoff", 32'(bus.dbg_state), 32'h3);
    check("ho_flt3", 32'(bus.trigflt), 32'h8);
    tick(17);
    check("ho_ignored_state", 32'(bus.dbg_state), 32'h0);
    check("ho_ignored_tout", 32'(bus.trig_out), 32'h0);
    check("ho_ignored_antsel", 32'(bus.antsel), 32'h1);
    check("ho_ignored_cnt", 32'(bus.trig_cnt), 32'(exp_cnt));
    bus.trig_in = '0;
    tick(20);

    // hold-off: edge 6 cycles after filtered release is accepted
    bus.trig_in = 4'b0010;
    expect_trig(1);
    tick(15);
    bus.trig_in = '0;
    tick(6);
    bus.trig_in = 4'b1000;
    expect_trig(3);
    tick(12);
    check("ho2_pulse", 32'(bus.trig_pulse), 32'h1);
    check("ho2_antsel", 32'(bus.antsel), 32'h3);
    check("ho2_cnt", 32'(bus.trig_cnt), 32'(exp_cnt));
    bus.trig_in = '0;
    tick(25);

    // filtered bit high for a single cycle: released during DELAY
    force dut.flt = 4'b0001;
    tick(1);
    check("rdly_in_delay", 32'(bus.dbg_state), 32'h1);
    release dut.flt;
    tick(1);
    check("rdly_back_idle", 32'(bus.dbg_state), 32'h0);
    check("rdly_no_pulse", 32'(bus.trig_pulse), 32'h0);
    check("rdly_cnt", 32'(bus.trig_cnt), 32'(exp_cnt));
    check("rdly_antsel", 32'(bus.antsel), 32'h3);
    tick(5);

    // random single triggers to push the 2-bit counter past saturation
    for (int k = 0; k < 2; k++) begin
      rb   = $urandom_range(0, N_TRIG - 1);
      rlen = $urandom_range(12, 20);
      bus.trig_in = 4'(1 << rb);
      expect_trig(rb);
      tick(rlen);
      bus.trig_in = '0;
      tick(25);
    end
    check("cnt_main", 32'(bus.trig_cnt), 32'(exp_cnt));
    check("cnt_sat_w2", 32'(bus2.trig_cnt), (exp_cnt > 3) ? 32'd3 : 32'(exp_cnt));
    check("w2_antsel", 32'(bus2.antsel), 32'(last_sel));

    // ENABLE dropped in ACTIVE
    bus.trig_in = 4'b0100;
    expect_trig(2);
    tick(13);
    check("en_tout_before", 32'(bus.trig_out), 32'h1);
    bus.enable = 1'b0;
    tick(1);
    check("en_tout_off", 32'(bus.trig_out), 32'h0);
    check("en_state_idle", 32'(bus.dbg_state), 32'h0);
    check("en_antsel_kept", 32'(bus.antsel), 32'h2);
    bus.trig_in = '0;
    tick(16);
    bus.enable = 1'b1;
    tick(5);
    check("en_cnt_kept", 32'(bus.trig_cnt), 32'(exp_cnt));
    check("en_rearm_idle", 32'(bus.dbg_state), 32'h0);

    // RST asserted while in DELAY
    bus.trig_in = 4'b0010;
    tick(11);
    check("rst_mid_in_delay", 32'(bus.dbg_state), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_antsel", 32'(bus.antsel), 32'h7);
    check("rst_mid_cnt", 32'(bus.trig_cnt), 32'h0);
    check("rst_mid_tout", 32'(bus.trig_out), 32'h0);
    check("rst_mid_flt", 32'(bus.trigflt), 32'h0);
    check("rst_mid_state", 32'(bus.dbg_state), 32'h0);
    check("rst_mid_cnt_w2", 32'(bus2.trig_cnt), 32'h0);
    bus.trig_in = '0;
    tick(3);
    rst = 1'b0;
    tick(30);
    check("post_rst_cnt", 32'(bus.trig_cnt), 32'h0);
    check("post_rst_antsel", 32'(bus.antsel), 32'h7);
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
